// File: rtl/iot_pio_pkg.sv
// Shared constants for the iot_pio_gen2 parallel I/O block: register word
// addresses, capture-edge encodings and the per-bit edge detector.
package iot_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_OUTSET  = 3'd1;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd2;
  localparam logic [2:0] ADDR_IRQMASK = 3'd3;
  localparam logic [2:0] ADDR_EDGECAP = 3'd4;
  localparam logic [2:0] ADDR_OUTRD   = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  function automatic logic [31:0] edge_sel(int et, logic [31:0] cur, logic [31:0] prev);
    case (et)
      EDGE_FALL: return ~cur & prev;
      EDGE_BOTH: return cur ^ prev;
      default:   return cur & ~prev;
    endcase
  endfunction

endpackage

// File: rtl/iot_pio_sync.sv
// Multi-stage input synchroniser plus one history flop, so the parent can
// compare the newest settled sample against the previous one.
module iot_pio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_hist
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;
  logic [WIDTH-1:0]                  r_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stage <= '0;
      r_hist  <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) r_stage[i] <= r_stage[i-1];
      r_hist <= r_stage[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_stage[SYNC_STAGES-1];
  assign o_hist = r_hist;

endmodule

// File: rtl/iot_pio_gen2.sv
// iot_pio_gen2: memory-mapped parallel I/O with synchronised inputs, edge capture and level irq.
// Define IOT_PIO_BITSET_EN to enable the OUTSET/OUTCLR write ports.
module iot_pio_gen2
  import iot_pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] r_out, r_mask, r_cap;
  logic [2:0]       r_warm;
  logic [WIDTH-1:0] w_sync, w_hist, w_wd, w_clr, w_edge;
  logic [31:0]      w_edge32, w_rd;
  logic             w_wr, w_unused_ok;

  iot_pio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .i_d    (in_port),
    .o_q    (w_sync),
    .o_hist (w_hist)
  );

  assign w_wr     = chipselect & ~write_n;
  assign w_wd     = writedata[WIDTH-1:0];
  assign w_clr    = (w_wr && address == ADDR_EDGECAP) ? w_wd : '0;
  assign w_edge32 = edge_sel(EDGE_TYPE, 32'(w_sync), 32'(w_hist));
  // Hold off capture until the reset zeros have left the synchroniser chain.
  assign w_edge   = (r_warm == WARM_DONE) ? w_edge32[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out  <= RESET_VALUE[WIDTH-1:0];
      r_mask <= '0;
      r_cap  <= '0;
      r_warm <= '0;
    end else begin
      if (r_warm != WARM_DONE) r_warm <= r_warm + 3'd1;
      if (w_wr) begin
        case (address)
          ADDR_DATA:    r_out  <= w_wd;
`ifdef IOT_PIO_BITSET_EN
          ADDR_OUTSET:  r_out  <= r_out | w_wd;
          ADDR_OUTCLR:  r_out  <= r_out & ~w_wd;
`endif
          ADDR_IRQMASK: r_mask <= w_wd;
          default: ;
        endcase
      end
      // A new edge beats a same-cycle clear.
      r_cap <= (r_cap & ~w_clr) | w_edge;
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_DATA:    w_rd[WIDTH-1:0] = w_sync;
      ADDR_IRQMASK: w_rd[WIDTH-1:0] = r_mask;
      ADDR_EDGECAP: w_rd[WIDTH-1:0] = r_cap;
      ADDR_OUTRD:   w_rd[WIDTH-1:0] = r_out;
      default: ;
    endcase
  end

  assign readdata    = w_rd;
  assign out_port    = r_out;
  assign irq         = |(r_cap & r_mask);
  assign w_unused_ok = &{1'b0, writedata, w_edge32};

endmodule

// File: tb/tb_iot_pio_gen2.sv
// Bench for iot_pio_gen2: an 8-bit rising-edge instance and a 4-bit either-edge
// instance share one bus and are checked against a cycle-indexed history model.
module tb_iot_pio_gen2;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [2:0]  address    = '0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = '0;
  logic [7:0]  in8        = '0;
  logic [31:0] rd8, rd4;
  logic [7:0]  out8;
  logic [3:0]  out4;
  logic        irq8, irq4;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_out  [2];
  logic [31:0] m_mask [2];
  logic [31:0] m_cap  [2];
  logic [31:0] vh     [0:1023];
  int          k = 0;

  always #5 clk = ~clk;

  iot_pio_gen2 #(.WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd8),
    .in_port(in8), .out_port(out8), .irq(irq8));

  iot_pio_gen2 #(.WIDTH(4), .RESET_VALUE(32'h3), .EDGE_TYPE(2), .SYNC_STAGES(3)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd4),
    .in_port(in8[3:0]), .out_port(out4), .irq(irq4));

  function automatic logic [31:0] wmask(int dd); return (dd == 0) ? 32'hFF : 32'hF; endfunction
  function automatic int pss(int dd); return (dd == 0) ? 2 : 3; endfunction
  function automatic int pet(int dd); return (dd == 0) ? 0 : 2; endfunction

  // Expected read value: DATA is the input sample from SYNC_STAGES-1 edges ago.
  function automatic logic [31:0] mread(int dd, logic [2:0] a);
    int idx = k - pss(dd) + 1;
    case (a)
      3'd0:    return (idx >= 1) ? (vh[idx] & wmask(dd)) : 32'h0;
      3'd3:    return m_mask[dd];
      3'd4:    return m_cap[dd];
      3'd5:    return m_out[dd];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic mirq(int dd); return |(m_cap[dd] & m_mask[dd]); endfunction

  task automatic model_reset;
    m_out[0] = 32'hA5; m_out[1] = 32'h3;
    for (int dd = 0; dd < 2; dd++) begin m_mask[dd] = '0; m_cap[dd] = '0; end
    k = 0;
    vh[0] = '0;
  endtask

  // One clock: drive the bus and inputs, take the edge, advance the model.
  task automatic step(input logic cs, input logic wn, input logic [2:0] a,
                      input logic [31:0] d, input logic [7:0] inp);
    logic [31:0] m, wd, ev, prev, cur;
    int s;
    chipselect = cs; write_n = wn; address = a; writedata = d; in8 = inp;
    @(posedge clk);
    k++;
    vh[k] = {24'h0, inp};
    for (int dd = 0; dd < 2; dd++) begin
      m = wmask(dd); wd = d & m; s = pss(dd); ev = '0;
      if (k >= s + 2) begin
        prev = vh[k-s-1] & m;
        cur  = vh[k-s] & m;
        case (pet(dd))
          0:       ev = cur & ~prev;
          1:       ev = ~cur & prev;
          default: ev = cur ^ prev;
        endcase
      end
      if (cs && !wn) begin
        case (a)
          3'd0: m_out[dd] = wd;
`ifdef IOT_PIO_BITSET_EN
          3'd1: m_out[dd] = m_out[dd] | wd;
          3'd2: m_out[dd] = m_out[dd] & ~wd;
`endif
          3'd3: m_mask[dd] = wd;
          3'd4: m_cap[dd] = m_cap[dd] & ~wd;
          default: ;
        endcase
      end
      m_cap[dd] = m_cap[dd] | ev;
    end
    #1;
  endtask

  task automatic apply_reset(input logic [7:0] inp);
    in8 = inp; chipselect = 1'b0; write_n = 1'b1; reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    in8 = 8'h5A; chipselect = 1'b1; write_n = 1'b1; writedata = '0; address = 3'd0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (out8 !== 8'hA5) begin n_err++; $display("FAIL reset_out8 got=%h exp=a5", out8); end
    n_vec++; if (out4 !== 4'h3)  begin n_err++; $display("FAIL reset_out4 got=%h exp=3", out4); end
    n_vec++; if (irq8 !== 1'b0 || irq4 !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b%b exp=00", irq8, irq4); end
    n_vec++; if (rd8 !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", rd8); end
    address = 3'd3; #1;
    n_vec++; if (rd8 !== 32'h0) begin n_err++; $display("FAIL reset_mask got=%h exp=0", rd8); end
    address = 3'd4; #1;
    n_vec++; if (rd8 !== 32'h0 || rd4 !== 32'h0) begin n_err++; $display("FAIL reset_cap got=%h/%h exp=0", rd8, rd4); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_warmup;
    apply_reset(8'hFF);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 3'd4, 32'h0, 8'hFF);
      n_vec++; if (rd8 !== 32'h0 || rd4 !== 32'h0) begin n_err++; $display("FAIL warmup_cap cyc=%0d got=%h/%h exp=0", i, rd8, rd4); end
    end
    address = 3'd0; #1;
    n_vec++; if (rd8 !== 32'hFF || rd4 !== 32'hF) begin n_err++; $display("FAIL warmup_data got=%h/%h exp=ff/f", rd8, rd4); end
  endtask

  task automatic test_edge_latency;
    apply_reset(8'h00);
    repeat (5) step(1'b1, 1'b1, 3'd4, 32'h0, 8'h00);
    step(1'b1, 1'b1, 3'd4, 32'h0, 8'h08);
    n_vec++; if (rd8 !== 32'h0) begin n_err++; $display("FAIL lat_c1 got=%h exp=0", rd8); end
    step(1'b1, 1'b1, 3'd4, 32'h0, 8'h08);
    n_vec++; if (rd8 !== 32'h0) begin n_err++; $display("FAIL lat_c2 got=%h exp=0", rd8); end
    step(1'b1, 1'b1, 3'd4, 32'h0, 8'h08);
    n_vec++; if (rd8 !== 32'h8) begin n_err++; $display("FAIL lat_c3 got=%h exp=8", rd8); end
    repeat (5) step(1'b1, 1'b1, 3'd4, 32'h0, 8'h00);
    n_vec++; if (rd8 !== 32'h8) begin n_err++; $display("FAIL fall_ignored got=%h exp=8", rd8); end
    n_vec++; if (rd4 !== mread(1, 3'd4)) begin n_err++; $display("FAIL either_edge got=%h exp=%h", rd4, mread(1, 3'd4)); end
    address = 3'd0; #1;
    n_vec++; if (rd8 !== mread(0, 3'd0)) begin n_err++; $display("FAIL data_read got=%h exp=%h", rd8, mread(0, 3'd0)); end
  endtask

  task automatic test_irq;
    step(1'b1, 1'b0, 3'd3, 32'h08, 8'h00);
    n_vec++; if (irq8 !== 1'b1) begin n_err++; $display("FAIL irq_set got=%b exp=1", irq8); end
    step(1'b1, 1'b0, 3'd4, 32'h08, 8'h00);
    n_vec++; if (irq8 !== 1'b0 || rd8 !== 32'h0) begin n_err++; $display("FAIL irq_clear got=%b cap=%h exp=0/0", irq8, rd8); end
    repeat (3) step(1'b0, 1'b1, 3'd4, 32'h0, 8'h08);
    n_vec++; if (irq8 !== 1'b1) begin n_err++; $display("FAIL irq_reedge got=%b exp=1", irq8); end
    step(1'b1, 1'b0, 3'd3, 32'h0, 8'h08);
    address = 3'd4; write_n = 1'b1; #1;
    n_vec++; if (irq8 !== 1'b0 || rd8 !== 32'h8) begin n_err++; $display("FAIL irq_masked got=%b cap=%h exp=0/8", irq8, rd8); end
    n_vec++; if (irq4 !== mirq(1)) begin n_err++; $display("FAIL irq4 got=%b exp=%b", irq4, mirq(1)); end
  endtask

  task automatic test_simultaneous;
    step(1'b1, 1'b0, 3'd4, 32'h08, 8'h08);
    n_vec++; if (rd8 !== 32'h0) begin n_err++; $display("FAIL simul_pre got=%h exp=0", rd8); end
    repeat (4) step(1'b0, 1'b1, 3'd4, 32'h0, 8'h00);
    step(1'b0, 1'b1, 3'd4, 32'h0, 8'h08);
    step(1'b0, 1'b1, 3'd4, 32'h0, 8'h08);
    step(1'b1, 1'b0, 3'd4, 32'h08, 8'h08);
    n_vec++; if (rd8 !== 32'h8) begin n_err++; $display("FAIL simul_edge_wins got=%h exp=8", rd8); end
    step(1'b1, 1'b0, 3'd4, 32'h08, 8'h08);
    n_vec++; if (rd8 !== 32'h0) begin n_err++; $display("FAIL simul_then_clear got=%h exp=0", rd8); end
  endtask

  task automatic test_set_clear;
    logic [7:0] e8;
    logic [3:0] e4;
    logic [2:0] ra [4];
`ifdef IOT_PIO_BITSET_EN
    e8 = 8'hFC; e4 = 4'hC;
`else
    e8 = 8'h0F; e4 = 4'hF;
`endif
    ra = '{3'd1, 3'd2, 3'd6, 3'd7};
    step(1'b1, 1'b0, 3'd0, 32'h0F, 8'h00);
    step(1'b1, 1'b0, 3'd1, 32'hF0, 8'h00);
    step(1'b1, 1'b0, 3'd2, 32'h03, 8'h00);
    address = 3'd5; write_n = 1'b1; #1;
    n_vec++; if (out8 !== e8 || rd8 !== {24'h0, e8}) begin n_err++; $display("FAIL setclr8 out=%h rd=%h exp=%h", out8, rd8, e8); end
    n_vec++; if (out4 !== e4) begin n_err++; $display("FAIL setclr4 out=%h exp=%h", out4, e4); end
    for (int i = 0; i < 4; i++) begin
      address = ra[i]; #1;
      n_vec++; if (rd8 !== 32'h0 || rd4 !== 32'h0) begin n_err++; $display("FAIL read_zero addr=%0d got=%h/%h exp=0", ra[i], rd8, rd4); end
    end
    step(1'b1, 1'b0, 3'd5, 32'hFFFF_FFFF, 8'h00);
    step(1'b1, 1'b0, 3'd6, 32'hFFFF_FFFF, 8'h00);
    step(1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF, 8'h00);
    address = 3'd3; write_n = 1'b1; #1;
    n_vec++; if (out8 !== e8 || rd8 !== m_mask[0]) begin n_err++; $display("FAIL ignored_writes out=%h mask=%h exp=%h/%h", out8, rd8, e8, m_mask[0]); end
  endtask

  task automatic test_width;
    step(1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF, 8'h00);
    address = 3'd5; write_n = 1'b1; #1;
    n_vec++; if (out4 !== 4'hF || rd4 !== 32'h0000_000F) begin n_err++; $display("FAIL width4 out=%h rd=%h exp=f/0000000f", out4, rd4); end
    n_vec++; if (out8 !== 8'hFF || rd8 !== 32'h0000_00FF) begin n_err++; $display("FAIL width8 out=%h rd=%h exp=ff/000000ff", out8, rd8); end
    step(1'b0, 1'b0, 3'd0, 32'h0, 8'h00);
    n_vec++; if (out8 !== 8'hFF) begin n_err++; $display("FAIL cs_qualify out=%h exp=ff", out8); end
  endtask

  task automatic test_random;
    logic [7:0]  inp;
    logic        c, w;
    logic [2:0]  a;
    logic [31:0] d;
    apply_reset(8'h00);
    inp = 8'h00;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) inp = inp ^ 8'($urandom);
      c = ($urandom_range(0, 3) != 0);
      w = 1'($urandom_range(0, 1));
      a = 3'($urandom);
      d = $urandom;
      step(c, w, a, d, inp);
      n_vec++; if (rd8 !== mread(0, a) || rd4 !== mread(1, a)) begin n_err++; $display("FAIL rand_read i=%0d addr=%0d got=%h/%h exp=%h/%h", i, a, rd8, rd4, mread(0, a), mread(1, a)); end
      n_vec++; if (out8 !== m_out[0][7:0] || out4 !== m_out[1][3:0]) begin n_err++; $display("FAIL rand_out i=%0d got=%h/%h exp=%h/%h", i, out8, out4, m_out[0][7:0], m_out[1][3:0]); end
      n_vec++; if (irq8 !== mirq(0) || irq4 !== mirq(1)) begin n_err++; $display("FAIL rand_irq i=%0d got=%b%b exp=%b%b", i, irq8, irq4, mirq(0), mirq(1)); end
    end
  endtask

  task automatic test_async_reset;
    step(1'b1, 1'b0, 3'd0, 32'h3C, 8'h00);
    step(1'b1, 1'b0, 3'd3, 32'hFF, 8'h00);
    write_n = 1'b1;
    reset_n = 1'b0;
    #1;
    n_vec++; if (out8 !== 8'hA5 || out4 !== 4'h3) begin n_err++; $display("FAIL async_out got=%h/%h exp=a5/3", out8, out4); end
    n_vec++; if (rd8 !== 32'h0 || irq8 !== 1'b0) begin n_err++; $display("FAIL async_mask rd=%h irq=%b exp=0/0", rd8, irq8); end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_edge_latency();
    test_irq();
    test_simultaneous();
    test_set_clear();
    test_width();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
